// File: rtl/uart_rx_if.sv
// Parallel-side bundle of the 8N1 UART receiver: serial line in, byte/strobes out.
// slave is the receiver's view; master is the line driver / byte consumer.
interface uart_rx_if;
  logic       Rx_i;
  logic [7:0] Data_o;
  logic       Done_o;
  logic       Busy_o;
  logic       FrameError_o;

  modport master (output Rx_i, input Data_o, Done_o, Busy_o, FrameError_o);
  modport slave  (input Rx_i, output Data_o, Done_o, Busy_o, FrameError_o);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with start-glitch rejection and framing-error flag.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote over the last three synchronized samples.
module uart_rx #(
  parameter int CLOCK_HZ = 10_000_000,
  parameter int BAUD     = 100_000
) (
  input logic       Clock,
  input logic       Reset,
  uart_rx_if.slave  bus
);

  localparam int TICKS = CLOCK_HZ / BAUD;
  localparam int HALF  = TICKS / 2;
  localparam int CW    = $clog2(TICKS);

  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] TICKS_M1 = CW'(TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          sync1_q, sync1_d;
  logic          rx_sync_q, rx_sync_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          fe_q, fe_d;
  logic          busy_q, busy_d;
  logic          sample_s;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0]    hist_q, hist_d;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Vote over the values seen at P-2, P-1 and P so a one-clock spike cannot flip a bit.
  always_comb begin
    hist_d   = {hist_q[0], rx_sync_q};
    sample_s = maj3(rx_sync_q, hist_q[0], hist_q[1]);
  end
`else
  // Single sample taken at the nominal point.
  always_comb begin
    sample_s = rx_sync_q;
  end
`endif

  // State register: synchronizer, FSM, counters, datapath and registered outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1_q   <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      fe_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      hist_q    <= 2'b11;
`endif
    end else begin
      sync1_q   <= sync1_d;
      rx_sync_q <= rx_sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      fe_q      <= fe_d;
      busy_q    <= busy_d;
`ifdef UART_RX_MAJORITY_EN
      hist_q    <= hist_d;
`endif
    end
  end

  // Next-state logic: counter clears on every state entry and bit boundary.
  always_comb begin
    sync1_d   = bus.Rx_i;
    rx_sync_d = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_ONE;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        if (!rx_sync_q) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!sample_s) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (cnt_q == TICKS_M1) begin
          cnt_d     = '0;
          shift_d   = {sample_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (cnt_q == TICKS_M1) begin
          cnt_d = '0;
          if (sample_s) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        // A held-low (break) line must not look like a fresh start bit.
        if (rx_sync_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // Output logic: strobes and data update are decided at the stop sample.
  always_comb begin
    data_d = data_q;
    done_d = 1'b0;
    fe_d   = 1'b0;
    busy_d = (state_d != IDLE);
    if ((state_q == STOP) && (cnt_q == TICKS_M1)) begin
      if (sample_s) begin
        data_d = shift_q;
        done_d = 1'b1;
      end else begin
        fe_d   = 1'b1;
      end
    end else begin
      data_d = data_q;
    end
  end

  assign bus.Data_o       = data_q;
  assign bus.Done_o       = done_q;
  assign bus.Busy_o       = busy_q;
  assign bus.FrameError_o = fe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default rate (TICKS=100, HALF=50).
module tb_uart_rx;

  localparam int T = 100;
  localparam int H = 50;

  logic Clock;
  logic Reset;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   done_cnt;
  int   fe_cnt;
  int   last_done_cyc;
  logic both_seen;
  logic [7:0] rxq [$];

  uart_rx_if u_if ();

  uart_rx u_dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (u_if.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Pulse monitor sampled away from the active edge.
  always @(negedge Clock) begin
    if (u_if.Done_o === 1'b1) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
      rxq.push_back(u_if.Data_o);
    end
    if (u_if.FrameError_o === 1'b1) fe_cnt = fe_cnt + 1;
    if ((u_if.Done_o === 1'b1) && (u_if.FrameError_o === 1'b1)) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Drives one 8N1 frame cycle by cycle; optional one-clock high spike at each data sample point.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic glitch, input int cut);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < cut; i++) begin
      logic lvl;
      lvl = bits[i / T];
      if (glitch && (i >= H + T) && (i <= H + 8 * T) && (((i - H) % T) == 0)) lvl = 1'b1;
      u_if.Rx_i = lvl;
      @(posedge Clock);
      #1;
    end
  endtask

  logic [7:0] hello [7];
  logic [7:0] exp_glitch;
  int start_cyc;
  int base_done;
  int base_fe;

  initial begin
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h21};
`ifdef UART_RX_MAJORITY_EN
    exp_glitch = 8'h00;
`else
    exp_glitch = 8'hFF;
`endif
    cyc = 0; n_checks = 0; n_pass = 0; done_cnt = 0; fe_cnt = 0;
    last_done_cyc = 0; both_seen = 1'b0;
    Reset = 1'b0;
    u_if.Rx_i = 1'b1;
    cycles(3);
    @(negedge Clock);
    check("rst_data", {24'd0, u_if.Data_o}, 32'h00);
    check("rst_done", {31'd0, u_if.Done_o}, 32'd0);
    check("rst_busy", {31'd0, u_if.Busy_o}, 32'd0);
    check("rst_fe", {31'd0, u_if.FrameError_o}, 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    cycles(5);

    // Single good frame and its latency
    start_cyc = cyc;
    send_frame(8'h48, 1'b1, 1'b0, 10 * T);
    cycles(5);
    check("f48_count", done_cnt, 32'd1);
    check("f48_data", {24'd0, u_if.Data_o}, 32'h48);
    check("f48_fe", fe_cnt, 32'd0);
    check("f48_latency", {31'd0, ((last_done_cyc - start_cyc) >= 953) && ((last_done_cyc - start_cyc) <= 955)}, 32'd1);

    // Back-to-back string
    rxq.delete();
    base_done = done_cnt;
    for (int k = 0; k < 7; k++) send_frame(hello[k], 1'b1, 1'b0, 10 * T);
    cycles(10);
    check("hello_count", done_cnt - base_done, 32'd7);
    check("hello_qlen", rxq.size(), 32'd7);
    for (int k = 0; k < 7; k++) begin
      if (k < rxq.size()) check($sformatf("hello_b%0d", k), {24'd0, rxq[k]}, {24'd0, hello[k]});
    end
    check("hello_fe", fe_cnt, 32'd0);

    // 30-clock low glitch on the start bit
    base_done = done_cnt;
    u_if.Rx_i = 1'b0;
    cycles(30);
    u_if.Rx_i = 1'b1;
    repeat (22) @(posedge Clock);
    @(negedge Clock);
    check("glitch_busy_hi", {31'd0, u_if.Busy_o}, 32'd1);
    @(posedge Clock);
    @(negedge Clock);
    check("glitch_busy_lo", {31'd0, u_if.Busy_o}, 32'd0);
    cycles(20);
    check("glitch_no_done", done_cnt - base_done, 32'd0);

    // Framing error followed by a held-low line, then a good frame
    base_done = done_cnt;
    base_fe = fe_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 10 * T);
    cycles(200);
    check("fe_count", fe_cnt - base_fe, 32'd1);
    check("fe_data_kept", {24'd0, u_if.Data_o}, 32'h21);
    check("fe_busy_hold", {31'd0, u_if.Busy_o}, 32'd1);
    check("fe_no_done", done_cnt - base_done, 32'd0);
    u_if.Rx_i = 1'b1;
    cycles(5);
    check("fe_busy_release", {31'd0, u_if.Busy_o}, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, 10 * T);
    cycles(5);
    check("after_fe_data", {24'd0, u_if.Data_o}, 32'h3C);
    check("after_fe_count", done_cnt - base_done, 32'd1);

    // Reset in the middle of data bit 4
    base_done = done_cnt;
    base_fe = fe_cnt;
    send_frame(8'h55, 1'b1, 1'b0, 5 * T + H);
    Reset = 1'b0;
    u_if.Rx_i = 1'b1;
    #2;
    check("mid_rst_data", {24'd0, u_if.Data_o}, 32'h00);
    check("mid_rst_busy", {31'd0, u_if.Busy_o}, 32'd0);
    cycles(3);
    Reset = 1'b1;
    cycles(10);
    check("mid_rst_no_pulse", (done_cnt - base_done) + (fe_cnt - base_fe), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 10 * T);
    cycles(5);
    check("post_rst_data", {24'd0, u_if.Data_o}, 32'h81);
    check("post_rst_count", done_cnt - base_done, 32'd1);

    // One-clock spikes at every data sample point
    base_done = done_cnt;
    send_frame(8'h00, 1'b1, 1'b1, 10 * T);
    cycles(5);
    check("spike_data", {24'd0, u_if.Data_o}, {24'd0, exp_glitch});
    check("spike_count", done_cnt - base_done, 32'd1);
    check("total_fe", fe_cnt, 32'd1);
    check("done_fe_exclusive", {31'd0, both_seen}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly downstream of the UART transmit path: it consumes an 8N1 UART line, such as the `Tx_o` of the string streamer, and delivers each received byte as a parallel word with a one-cycle strobe. Its default rate of 100 000 baud at a 10 MHz clock matches the transmit side, so the two can be looped back on-chip for self-test. It also rejects start-bit glitches and flags framing errors.

## Interface
- `CLOCK_HZ`, default 10_000_000: system clock frequency in Hz.
- `BAUD`, default 100_000: line rate in bit/s. `TICKS = CLOCK_HZ/BAUD` (integer division) must be ≥ 8. `HALF = TICKS/2`.
- `Clock`  in  1  system clock; all logic is on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Rx_i`  in  1  serial line, asynchronous to `Clock`; idles high.
- `Data_o`  out  8  last correctly framed byte; holds until the next good frame.
- `Done_o`  out  1  one-cycle pulse when `Data_o` has just been updated.
- `Busy_o`  out  1  high whenever the FSM is not in IDLE.
- `FrameError_o`  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- `Rx_i` passes through a 2-FF synchronizer; both flops reset to 1. `RxSync` is the second flop. All decisions use `RxSync` only.
- The FSM has five states: IDLE, START, DATA, STOP, WAIT_IDLE. A clock counter (width ⌈log2 TICKS⌉) clears on every state entry and at every bit boundary. A 3-bit bit index and an 8-bit shift register are also kept.
- IDLE → START when `RxSync == 0`.
- START: sample at count == HALF-1.
  - Sample 0: go to DATA.
  - Sample 1: treat as a glitch and return to IDLE with no output pulse.
- DATA: sample at count == TICKS-1 and shift in LSB first (shift register right-shift, new bit into bit 7). After bit index 7 → STOP.
- STOP: sample at count == TICKS-1.
  - Sample 1: load `Data_o` from the shift register, pulse `Done_o`, go to IDLE.
  - Sample 0: pulse `FrameError_o`, leave `Data_o` unchanged, go to WAIT_IDLE.
- WAIT_IDLE → IDLE on the first `RxSync == 1`. This prevents a break or stuck-low line from retriggering.
- `Done_o` and `FrameError_o` are never high in the same cycle.
- `Rx_i` activity while `Busy_o` is high is handled only by the FSM; there is no overrun detection. Downstream must capture `Data_o` within one frame time.

## Timing
- Reset values:
  - `Data_o` = 8'h00; `Done_o`, `Busy_o`, `FrameError_o` = 0.
  - FSM = IDLE; counter, bit index and shift register = 0; synchronizer = 1.
- Reset asserted mid-frame aborts immediately, with no pulse. After release, the FSM restarts from IDLE on the next low `RxSync`.
- `Busy_o` rises 1 clock after `RxSync` first reads 0, that is, 3 clocks after the `Rx_i` falling edge (±1 for async alignment).
- Sample points, measured from START entry:
  - start bit: HALF clocks;
  - data bit n: HALF + (n+1)·TICKS clocks;
  - stop bit: HALF + 9·TICKS clocks.
- `Done_o` and `FrameError_o` are registered and high in the clock after the stop sample. `Busy_o` falls in that same clock.
- Defaults (TICKS = 100, HALF = 50): `Done_o` is high 3 + 50 + 900 + 1 = 954 clocks after the `Rx_i` falling edge, ±1.
- Back-to-back frames: a start edge arriving one clock after the IDLE re-entry is accepted.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each sample (start, data, stop) is the 2-of-3 majority of `RxSync` at nominal point P-2, P-1 and P.
  - The decision is taken at P, so timing is unchanged.
  - A single-clock glitch at a sample point is rejected.
- Not defined: the single sample at P is used and the majority logic is absent.

## Test plan
- Send 8'h48 at the default baud with a correct stop bit → exactly one `Done_o` pulse at 954±1 clocks and `Data_o` = 8'h48; `FrameError_o` stays 0.
- Loop back from the string streamer, sending "Hello!!" back-to-back → 7 `Done_o` pulses with `Data_o` = 48, 65, 6C, 6C, 6F, 21, 21; no errors.
- Drive `Rx_i` low for 30 clocks, then high → `Busy_o` pulses high, no `Done_o`, FSM returns to IDLE at count HALF.
- Frame 8'hA5 with the stop bit low, holding low 200 further clocks → one `FrameError_o` pulse; `Data_o` keeps its prior value; `Busy_o` stays high until `Rx_i` returns high; a following good 8'h3C frame is received correctly.
- Assert `Reset` during data bit 4, release, then send 8'h81 → no pulse from the aborted frame; outputs at reset values; `Data_o` = 8'h81 after the new frame.
- With `UART_RX_MAJORITY_EN`, send 8'h00 with a 1-clock high glitch at each data sample point → `Data_o` = 8'h00. Without the macro, the same stimulus gives 8'hFF.
